snoop_txn_arbiter: RTL and testbench

SNOOP_TXN_ARBITER -- requirements
Module: snoop_txn_arbiter

---
 rtl/snoop_txn_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_snoop_txn_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_txn_arbiter.sv
// -----------------------------------------------------------------------------
// snoop_txn_arbiter
//
// Round-robin arbiter for a snooping coherence bus. One request is granted at
// a time. Its type and address are broadcast to every other cache controller
// for snooping. The arbiter collects their acks and "line held" (shared)
// indications. The transaction completes with a one-cycle done/ready pulse,
// either when every non-granted core has acked or when the snoop-wait counter
// expires.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   req_valid[N]     per-core bus request
//   req_type[N][2]   01=READ, 10=WRITE, 11=UPGRADE, 00=none (ignored)
//   req_addr[N][AW]  per-core request address
//   req_ready[N]     one-cycle completion pulse to the granted core
//   bus_valid        snoop broadcast active (SNOOP state)
//   bus_type         latched type of the granted request
//   bus_addr         latched address of the granted request
//   granted_core_id  index of the granted core
//   snoop_ack[N]     per-core snoop completion
//   snoop_shared[N]  per-core line-held flag, qualified by snoop_ack
//   txn_done         one-cycle pulse at transaction completion
//   txn_shared       OR of the collected shared flags, valid with txn_done
//   txn_timeout      completion was forced by the snoop-wait timeout
// -----------------------------------------------------------------------------
module snoop_txn_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int ADDR_WIDTH    = 64,
    parameter int SNOOP_TIMEOUT = 15,
    localparam int ID_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CORES-1:0]                  req_valid,
    input  logic [NUM_CORES-1:0][1:0]             req_type,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  req_addr,
    output logic [NUM_CORES-1:0]                  req_ready,
    output logic                                  bus_valid,
    output logic [1:0]                            bus_type,
    output logic [ADDR_WIDTH-1:0]                 bus_addr,
    output logic [ID_W-1:0]                       granted_core_id,
    input  logic [NUM_CORES-1:0]                  snoop_ack,
    input  logic [NUM_CORES-1:0]                  snoop_shared,
    output logic                                  txn_done,
    output logic                                  txn_shared,
    output logic                                  txn_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0]      TIMEOUT_CNT = 8'(SNOOP_TIMEOUT);
    localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_CORES - 1);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [1:0]              type_q, type_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NUM_CORES-1:0]    ack_seen_q, ack_seen_d;
    logic                    shared_acc_q, shared_acc_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic                    timeout_q, timeout_d;

    logic [NUM_CORES-1:0]    eligible;
    logic [NUM_CORES-1:0]    granted_mask;
    logic                    grant_found;
    logic [ID_W-1:0]         grant_idx;
    logic [7:0]              wait_cnt_inc;

    // A core only competes when it presents a real request type.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_elig
            assign eligible[gi] = req_valid[gi] && (req_type[gi] != 2'b00);
        end
    endgenerate

    assign granted_mask = NUM_CORES'(1) << id_q;
    assign wait_cnt_inc = wait_cnt_q + 8'd1;

    // Round-robin search: first eligible core at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        type_d       = type_q;
        addr_d       = addr_q;
        ack_seen_d   = ack_seen_q;
        shared_acc_d = shared_acc_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d      = ST_SNOOP;
                    id_d         = grant_idx;
                    type_d       = req_type[grant_idx];
                    addr_d       = req_addr[grant_idx];
                    ack_seen_d   = '0;
                    shared_acc_d = 1'b0;
                    wait_cnt_d   = '0;
                    timeout_d    = 1'b0;
                end
            end
            ST_SNOOP: begin
                // The granted core does not snoop its own request.
                ack_seen_d   = ack_seen_q | (snoop_ack & ~granted_mask);
                shared_acc_d = shared_acc_q |
                               (|(snoop_ack & snoop_shared & ~granted_mask));
                wait_cnt_d   = wait_cnt_inc;
                // Completion wins over the timeout when both land together.
                if (&(ack_seen_d | granted_mask)) begin
                    state_d = ST_DONE;
                end else if (wait_cnt_inc >= TIMEOUT_CNT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            type_q       <= '0;
            addr_q       <= '0;
            ack_seen_q   <= '0;
            shared_acc_q <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            ack_seen_q   <= ack_seen_d;
            shared_acc_q <= shared_acc_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign bus_valid       = (state_q == ST_SNOOP);
    assign txn_done        = (state_q == ST_DONE);
    assign txn_shared      = txn_done && shared_acc_q;
    assign txn_timeout     = txn_done && timeout_q;
    assign req_ready       = txn_done ? granted_mask : '0;
    assign bus_type        = type_q;
    assign bus_addr        = addr_q;
    assign granted_core_id = id_q;

endmodule

// File: tb/tb_snoop_txn_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoop_txn_arbiter
//
// Directed stimulus with a scoreboard: each issued request pushes its expected
// completion; a monitor pops and compares whenever txn_done is seen.
// A responder process drives snoop_ack/snoop_shared from a per-core schedule
// (ack on SNOOP cycle N, 0 = never).
// -----------------------------------------------------------------------------
module tb_snoop_txn_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int TO = 15;

    localparam logic [1:0] T_RD  = 2'b01;
    localparam logic [1:0] T_WR  = 2'b10;
    localparam logic [1:0] T_UPG = 2'b11;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N-1:0]            req_valid;
    logic [N-1:0][1:0]       req_type;
    logic [N-1:0][AW-1:0]    req_addr;
    logic [N-1:0]            req_ready;
    logic                    bus_valid;
    logic [1:0]              bus_type;
    logic [AW-1:0]           bus_addr;
    logic [1:0]              granted_core_id;
    logic [N-1:0]            snoop_ack;
    logic [N-1:0]            snoop_shared;
    logic                    txn_done;
    logic                    txn_shared;
    logic                    txn_timeout;

    snoop_txn_arbiter #(
        .NUM_CORES     (N),
        .ADDR_WIDTH    (AW),
        .SNOOP_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_type        (req_type),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .bus_valid       (bus_valid),
        .bus_type        (bus_type),
        .bus_addr        (bus_addr),
        .granted_core_id (granted_core_id),
        .snoop_ack       (snoop_ack),
        .snoop_shared    (snoop_shared),
        .txn_done        (txn_done),
        .txn_shared      (txn_shared),
        .txn_timeout     (txn_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [1:0]  typ;
        logic [63:0] addr;
        logic        shared;
        logic        tmo;
        int          snoop;   // expected number of bus_valid cycles
        int          gap;     // expected cycles since previous done, 0 = skip
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ack_delay [N];
    logic ack_shr   [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [1:0] typ, input logic [63:0] addr,
                        input logic sh, input logic tmo, input int snoop, input int gap);
        exp_t e;
        e.id = id; e.typ = typ; e.addr = addr; e.shared = sh;
        e.tmo = tmo; e.snoop = snoop; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic set_acks(input int d0, input int d1, input int d2, input int d3,
                            input logic [3:0] s);
        ack_delay[0] = d0; ack_delay[1] = d1; ack_delay[2] = d2; ack_delay[3] = d3;
        for (int i = 0; i < N; i++) ack_shr[i] = s[i];
    endtask

    task automatic start_req(input int core, input logic [1:0] typ, input logic [63:0] addr);
        req_valid[core] = 1'b1;
        req_type[core]  = typ;
        req_addr[core]  = addr;
    endtask

    task automatic wait_bus();
        int n;
        n = 0;
        while (!bus_valid) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL wait_bus: bus_valid=0 after 50 cycles, required 1");
                return;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL wait_done: txn_done=0 after 60 cycles, required 1");
                return;
            end
        end while (!txn_done);
    endtask

    // Snoop responder: counts SNOOP cycles and acks per schedule.
    initial begin
        int scyc;
        scyc = 0;
        snoop_ack    = '0;
        snoop_shared = '0;
        forever begin
            @(negedge clk);
            if (bus_valid) scyc++;
            else           scyc = 0;
            for (int i = 0; i < N; i++) begin
                snoop_ack[i]    = bus_valid && (ack_delay[i] != 0) && (ack_delay[i] == scyc);
                snoop_shared[i] = snoop_ack[i] && ack_shr[i];
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        int   cyc;
        int   snoop_cnt;
        int   last_done;
        exp_t e;
        logic [N-1:0] exp_ready;
        cyc = 0; snoop_cnt = 0; last_done = -1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                snoop_cnt = 0;
                last_done = -1;
            end else begin
                if (bus_valid) snoop_cnt++;
                if (txn_done) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: txn_done=1 core=%0d, required no completion",
                                 granted_core_id);
                    end else begin
                        e = q.pop_front();
                        exp_ready = '0;
                        exp_ready[e.id] = 1'b1;
                        chk("granted_core_id", 64'(granted_core_id), 64'(e.id));
                        chk("req_ready", 64'(req_ready), 64'(exp_ready));
                        chk("bus_type", 64'(bus_type), 64'(e.typ));
                        chk("bus_addr", bus_addr, e.addr);
                        chk("txn_shared", 64'(txn_shared), 64'(e.shared));
                        chk("txn_timeout", 64'(txn_timeout), 64'(e.tmo));
                        chk("snoop_cycles", 64'(snoop_cnt), 64'(e.snoop));
                        if (e.gap != 0 && last_done >= 0)
                            chk("done_gap", 64'(cyc - last_done), 64'(e.gap));
                        $display("txn core=%0d type=%0d addr=0x%0h shared=%0d timeout=%0d snoop_cycles=%0d",
                                 granted_core_id, bus_type, bus_addr, txn_shared, txn_timeout, snoop_cnt);
                    end
                    snoop_cnt = 0;
                    last_done = cyc;
                end else begin
                    chk("no_pulse_outside_done", 64'({req_ready, txn_shared, txn_timeout}), 64'(0));
                end
            end
        end
    end

    // Stimulus
    initial begin
        req_valid = '0;
        req_type  = '0;
        req_addr  = '0;
        set_acks(0, 0, 0, 0, 4'b0000);

        // Reset state, with a request present that must not be granted
        req_valid[1] = 1'b1; req_type[1] = T_RD;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bus_valid", 64'(bus_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_txn_done", 64'(txn_done), 64'(0));
        chk("rst_bus_addr", bus_addr, 64'(0));
        chk("rst_bus_type", 64'(bus_type), 64'(0));
        chk("rst_granted_id", 64'(granted_core_id), 64'(0));
        chk("rst_txn_shared", 64'(txn_shared), 64'(0));
        chk("rst_txn_timeout", 64'(txn_timeout), 64'(0));
        req_valid = '0; req_type = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin: all cores request continuously, immediate acks
        set_acks(1, 1, 1, 1, 4'b0000);
        push(0, T_RD,  64'hA0, 1'b0, 1'b0, 1, 0);
        push(1, T_WR,  64'hA1, 1'b0, 1'b0, 1, 3);
        push(2, T_UPG, 64'hA2, 1'b0, 1'b0, 1, 3);
        push(3, T_RD,  64'hA3, 1'b0, 1'b0, 1, 3);
        push(0, T_RD,  64'hA0, 1'b0, 1'b0, 1, 3);
        start_req(0, T_RD,  64'hA0);
        start_req(1, T_WR,  64'hA1);
        start_req(2, T_UPG, 64'hA2);
        start_req(3, T_RD,  64'hA3);
        for (int k = 0; k < 5; k++) wait_done();
        req_valid = '0;
        repeat (2) @(negedge clk);

        // Single READ from core 2, core 1 holds the line
        set_acks(1, 1, 0, 1, 4'b0010);
        push(2, T_RD, 64'h1000, 1'b1, 1'b0, 1, 0);
        start_req(2, T_RD, 64'h1000);
        wait_bus();
        req_valid[2] = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);

        // Timeout: core 3 never acks; core 0's own ack/shared must be ignored
        set_acks(1, 1, 1, 0, 4'b0001);
        push(0, T_UPG, 64'h2000, 1'b0, 1'b1, TO, 0);
        start_req(0, T_UPG, 64'h2000);
        wait_bus();
        req_valid[0] = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);

        // Last ack lands on the timeout cycle: normal completion
        set_acks(1, 0, 1, TO, 4'b1000);
        push(1, T_RD, 64'h2400, 1'b1, 1'b0, TO, 0);
        start_req(1, T_RD, 64'h2400);
        wait_bus();
        req_valid[1] = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);

        // Staggered acks on cycles 1,4,7; core 3 holds a type-00 request
        set_acks(1, 0, 4, 7, 4'b0100);
        start_req(3, 2'b00, 64'h3333);
        push(1, T_RD, 64'h3000, 1'b1, 1'b0, 7, 0);
        start_req(1, T_RD, 64'h3000);
        wait_bus();
        req_valid[1] = 1'b0;
        wait_done();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("type00_not_granted", 64'(bus_valid), 64'(0));
        end
        req_valid[3] = 1'b0;

        // Latch stability: granted core changes address/type during SNOOP
        set_acks(3, 3, 0, 3, 4'b0000);
        push(2, T_RD, 64'h1000, 1'b0, 1'b0, 3, 0);
        start_req(2, T_RD, 64'h1000);
        wait_bus();
        @(negedge clk);
        req_addr[2] = 64'hDEAD;
        req_type[2] = T_WR;
        chk("latched_addr_snoop", bus_addr, 64'h1000);
        wait_done();
        req_valid[2] = 1'b0;
        repeat (2) @(negedge clk);

        // Reset on SNOOP cycle 2 abandons the transaction
        set_acks(0, 0, 0, 0, 4'b0000);
        start_req(1, T_RD, 64'h4000);
        wait_bus();
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_bus_valid", 64'(bus_valid), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        chk("midrst_txn_done", 64'(txn_done), 64'(0));
        chk("midrst_bus_addr", bus_addr, 64'(0));
        chk("midrst_granted_id", 64'(granted_core_id), 64'(0));
        repeat (2) @(negedge clk);
        set_acks(1, 1, 1, 1, 4'b0000);
        push(0, T_RD, 64'h5000, 1'b0, 1'b0, 1, 0);
        push(3, T_WR, 64'h5003, 1'b0, 1'b0, 1, 3);
        start_req(3, T_WR, 64'h5003);
        start_req(0, T_RD, 64'h5000);
        @(negedge clk);
        rst_n = 1'b1;
        wait_bus();
        req_valid[0] = 1'b0;
        wait_done();
        wait_bus();
        req_valid[3] = 1'b0;
        wait_done();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
